// File: rtl/mips_state_sequencer.sv
// mips_state_sequencer: multi-cycle MIPS phase sequencer with bus/ALU stall handling and a retired-instruction counter.
// Ports:
//   clk           system clock, all state changes on its rising edge
//   reset         synchronous active-low reset (0 = reset)
//   opcode        instruction bits [31:26]
//   func_code     instruction bits [5:0]
//   waitrequest   memory bus stall (1 = access not yet accepted)
//   alu_busy      multiply/divide unit still computing
//   pc_next       PC value after the current state's update
//   state         current phase (FETCH_INSTR..HALTED)
//   active        1 while executing, 0 in reset and HALTED
//   stall         1 in any cycle where the phase is held
//   instr_retired count of completed instructions (wraps)
module mips_state_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func_code,
  input  logic        waitrequest,
  input  logic        alu_busy,
  input  logic [31:0] pc_next,
  output logic [2:0]  state,
  output logic        active,
  output logic        stall,
  output logic [31:0] instr_retired
);
  localparam logic [2:0] FETCH_INSTR   = 3'b000;
  localparam logic [2:0] DECODE        = 3'b001;
  localparam logic [2:0] EXECUTE       = 3'b010;
  localparam logic [2:0] MEMORY_ACCESS = 3'b011;
  localparam logic [2:0] WRITE_BACK    = 3'b100;
  localparam logic [2:0] HALTED        = 3'b101;
  logic       is_load, is_store, is_muldiv, is_jr, retire;
  logic [2:0] next_state;
  // loads are 100000..100110; 100111 is not a load
  assign is_load   = opcode[5:3] == 3'b100 && opcode[2:0] != 3'b111;
  assign is_store  = opcode == 6'b101000 || opcode == 6'b101001 || opcode == 6'b101011;
  assign is_muldiv = opcode == 6'b000000 && func_code[5:2] == 4'b0110;
  assign is_jr     = opcode == 6'b000000 && func_code[5:1] == 5'b00100;
  assign stall = (state == FETCH_INSTR && waitrequest) ||
                 (state == EXECUTE && is_muldiv && alu_busy) ||
                 (state == MEMORY_ACCESS && (is_load || is_store) && waitrequest);
  // retirement happens leaving WRITE_BACK, or leaving MEMORY_ACCESS when not going to WRITE_BACK
  assign retire = state == WRITE_BACK || (state == MEMORY_ACCESS && !stall && !is_load);
  always_comb begin
    next_state = FETCH_INSTR;
    case (state)
      FETCH_INSTR:   next_state = stall ? FETCH_INSTR : DECODE;
      DECODE:        next_state = EXECUTE;
      EXECUTE:       next_state = stall ? EXECUTE : MEMORY_ACCESS;
      MEMORY_ACCESS: next_state = stall ? MEMORY_ACCESS : is_load ? WRITE_BACK :
                                  (is_jr && pc_next == 32'd0) ? HALTED : FETCH_INSTR;
      HALTED:        next_state = HALTED;
      default:       next_state = FETCH_INSTR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= FETCH_INSTR;
      active        <= 1'b0;
      instr_retired <= 32'd0;
    end else begin
      state         <= next_state;
      active        <= next_state != HALTED;
      instr_retired <= instr_retired + {31'd0, retire};
    end
  end
endmodule

// File: tb/tb_mips_state_sequencer.sv
// tb_mips_state_sequencer: table-driven, directed and randomized checks of mips_state_sequencer.
module tb_mips_state_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func_code = 6'd0;
  logic        waitrequest = 1'b0;
  logic        alu_busy = 1'b0;
  logic [31:0] pc_next = 32'd4;
  logic [2:0]  state;
  logic        active;
  logic        stall;
  logic [31:0] instr_retired;
  int checks = 0;
  int failures = 0;
  mips_state_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .waitrequest(waitrequest), .alu_busy(alu_busy), .pc_next(pc_next),
    .state(state), .active(active), .stall(stall), .instr_retired(instr_retired)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        wr;
    logic        bz;
    logic [31:0] pc;
    logic [2:0]  st;
    logic        stl;
    logic        act;
    logic [31:0] ret;
  } vec_t;
  vec_t tbl [19];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    waitrequest = 1'b0;
    alu_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  function automatic bit m_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
  endfunction
  function automatic bit m_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2b};
  endfunction
  function automatic bit m_muldiv(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h00 && fn inside {6'h18, 6'h19, 6'h1a, 6'h1b};
  endfunction
  function automatic bit m_jr(input logic [5:0] op, input logic [5:0] fn);
    return op == 6'h00 && fn inside {6'h08, 6'h09};
  endfunction
  initial begin
    int ph, hold, nph;
    logic [31:0] mret;
    bit mact;
    logic [5:0] ops [7];
    logic [5:0] fns [6];
    // after reset release: FETCH stall, ADDU, LW with 3 bus stalls, JR to 0 then halted
    tbl = '{
      '{6'h00, 6'h21, 1'b1, 1'b0, 32'h4, 3'd0, 1'b1, 1'b0, 32'd0},
      '{6'h00, 6'h21, 1'b0, 1'b0, 32'h4, 3'd0, 1'b0, 1'b1, 32'd0},
      '{6'h00, 6'h21, 1'b1, 1'b1, 32'h4, 3'd1, 1'b0, 1'b1, 32'd0},
      '{6'h00, 6'h21, 1'b0, 1'b1, 32'h4, 3'd2, 1'b0, 1'b1, 32'd0},
      '{6'h00, 6'h21, 1'b1, 1'b0, 32'h0, 3'd3, 1'b0, 1'b1, 32'd0},
      '{6'h23, 6'h00, 1'b0, 1'b0, 32'h4, 3'd0, 1'b0, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b1, 1'b0, 32'h4, 3'd1, 1'b0, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b1, 1'b1, 32'h4, 3'd2, 1'b0, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b1, 1'b0, 32'h4, 3'd3, 1'b1, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b1, 1'b0, 32'h4, 3'd3, 1'b1, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b1, 1'b0, 32'h4, 3'd3, 1'b1, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b0, 1'b0, 32'h4, 3'd3, 1'b0, 1'b1, 32'd1},
      '{6'h23, 6'h00, 1'b1, 1'b0, 32'h4, 3'd4, 1'b0, 1'b1, 32'd1},
      '{6'h00, 6'h08, 1'b0, 1'b0, 32'h4, 3'd0, 1'b0, 1'b1, 32'd2},
      '{6'h00, 6'h08, 1'b0, 1'b0, 32'h4, 3'd1, 1'b0, 1'b1, 32'd2},
      '{6'h00, 6'h08, 1'b0, 1'b0, 32'h4, 3'd2, 1'b0, 1'b1, 32'd2},
      '{6'h00, 6'h08, 1'b0, 1'b0, 32'h0, 3'd3, 1'b0, 1'b1, 32'd2},
      '{6'h23, 6'h00, 1'b1, 1'b1, 32'h4, 3'd5, 1'b0, 1'b0, 32'd3},
      '{6'h00, 6'h08, 1'b1, 1'b0, 32'h0, 3'd5, 1'b0, 1'b0, 32'd3}
    };
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 19; i++) begin
      opcode = tbl[i].op;
      func_code = tbl[i].fn;
      waitrequest = tbl[i].wr;
      alu_busy = tbl[i].bz;
      pc_next = tbl[i].pc;
      #1;
      chk($sformatf("tbl%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
      chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].stl});
      chk($sformatf("tbl%0d_active", i), {31'd0, active}, {31'd0, tbl[i].act});
      chk($sformatf("tbl%0d_retired", i), instr_retired, tbl[i].ret);
      @(negedge clk);
    end
    // DIV held in EXECUTE for 10 busy cycles
    do_reset();
    opcode = 6'h00;
    func_code = 6'h1a;
    pc_next = 32'h4;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      alu_busy = 1'b1;
      waitrequest = i[0];
      #1;
      chk("div_hold_state", {29'd0, state}, 32'd2);
      chk("div_hold_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
    end
    alu_busy = 1'b0;
    waitrequest = 1'b0;
    #1;
    chk("div_done_state", {29'd0, state}, 32'd2);
    chk("div_done_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("div_mem_state", {29'd0, state}, 32'd3);
    @(negedge clk);
    #1;
    chk("div_retired", instr_retired, 32'd1);
    // reset in a FETCH stall with 5 retired
    do_reset();
    opcode = 6'h00;
    func_code = 6'h21;
    repeat (20) @(negedge clk);
    waitrequest = 1'b1;
    #1;
    chk("pre_rst_retired", instr_retired, 32'd5);
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_retired", instr_retired, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    reset = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
    #1;
    chk("rel_active", {31'd0, active}, 32'd1);
    chk("rel_state", {29'd0, state}, 32'd1);
    // counter wrap
    do_reset();
    force dut.instr_retired = 32'hffff_ffff;
    #1;
    release dut.instr_retired;
    repeat (4) @(negedge clk);
    #1;
    chk("wrap_retired", instr_retired, 32'd0);
    chk("wrap_state", {29'd0, state}, 32'd0);
    // randomized run against a phase-level model
    ops = '{6'h00, 6'h23, 6'h20, 6'h2b, 6'h28, 6'h0f, 6'h27};
    fns = '{6'h21, 6'h1a, 6'h18, 6'h08, 6'h09, 6'h2a};
    do_reset();
    ph = 0;
    mret = 32'd0;
    mact = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(0, 79) != 0;
      opcode = $urandom_range(0, 9) == 0 ? 6'($urandom) : ops[$urandom_range(0, 6)];
      func_code = fns[$urandom_range(0, 5)];
      waitrequest = $urandom_range(0, 2) == 0;
      alu_busy = $urandom_range(0, 1) == 1;
      pc_next = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      #1;
      hold = (ph == 0 && waitrequest) ||
             (ph == 2 && m_muldiv(opcode, func_code) && alu_busy) ||
             (ph == 3 && (m_load(opcode) || m_store(opcode)) && waitrequest);
      chk("rnd_state", {29'd0, state}, ph);
      chk("rnd_stall", {31'd0, stall}, hold);
      chk("rnd_active", {31'd0, active}, {31'd0, mact});
      chk("rnd_retired", instr_retired, mret);
      if (!reset) begin
        ph = 0;
        mret = 32'd0;
        mact = 1'b0;
      end else begin
        if (hold) nph = ph;
        else if (ph == 3) nph = m_load(opcode) ? 4 : (m_jr(opcode, func_code) && pc_next == 0) ? 5 : 0;
        else if (ph == 4) nph = 0;
        else if (ph == 5) nph = 5;
        else nph = ph + 1;
        if (ph == 4 || (ph == 3 && nph != 3 && nph != 4)) mret = mret + 32'd1;
        mact = nph != 5;
        ph = nph;
      end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
